// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared trellis helpers (state count, FSM encoding, predecessor and decoded-bit functions).
// No ports; imported by viterbi_traceback and survivor-path logic.
package viterbi_pkg;
    localparam int MAX_K = 7;
    localparam int SW = MAX_K - 1;

    typedef enum logic [1:0] {IDLE, TRACE, FLUSH} trace_state_t;

    function automatic int ns_of(input int k);
        return 1 << (k - 1);
    endfunction

    // Drop the newest bit (MSB), shift up, and insert the stored decision as the oldest bit.
    function automatic logic [SW-1:0] pred_state(input logic [SW-1:0] s, input int k, input logic d);
        return ((s << 1) | SW'(d)) & SW'((1 << (k - 1)) - 1);
    endfunction

    function automatic logic dec_bit(input logic [SW-1:0] s, input int k);
        return s[k-2];
    endfunction
endpackage

// File: rtl/survivor_mem.sv
// survivor_mem: DEPTH x NS decision store, one write port, one combinational read port.
// Ports: clk; we/waddr/wdata write; raddr -> rdata read.
module survivor_mem #(
    parameter int DEPTH = 32,
    parameter int NS = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [NS-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [NS-1:0] rdata
);
    logic [NS-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/viterbi_traceback.sv
// viterbi_traceback: stores survivor decisions of a frame, then traces back from a given best state
// and emits decoded bits as OUT_W-bit words, newest word first.
// Ports: clk, rst (async, active-low); i_dec_valid/i_dec decision input; i_start/i_best_state
// frame end; o_data/o_valid/i_out_ready word output; o_done, o_busy, o_err, o_ovf status.
module viterbi_traceback import viterbi_pkg::*; #(
    parameter int K = 3,
    parameter int DEPTH = 32,
    parameter int OUT_W = 8,
    localparam int NS = ns_of(K),
    localparam int AW = $clog2(DEPTH),
    localparam int BW = $clog2(OUT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_dec_valid,
    input  logic [NS-1:0]    i_dec,
    input  logic             i_start,
    input  logic [K-2:0]     i_best_state,
    input  logic             i_out_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_valid,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_err,
    output logic             o_ovf
);
    trace_state_t state, state_d;
    logic [AW:0] cnt, n_len;
    logic [AW-1:0] ptr;
    logic [K-2:0] cur;
    logic [OUT_W-1:0] acc, acc_n;
    logic [NS-1:0] rd_vec;
    logic wr, start_ok, accept, word_end, step;

    survivor_mem #(.DEPTH(DEPTH), .NS(NS)) u_mem (
        .clk(clk), .we(wr), .waddr(cnt[AW-1:0]), .wdata(i_dec), .raddr(ptr), .rdata(rd_vec)
    );

    assign wr = state == IDLE && i_dec_valid && cnt != (AW+1)'(DEPTH);
    // A vector stored in the start cycle belongs to the frame.
    assign n_len = cnt + (AW+1)'(wr);
    assign start_ok = n_len != '0 && n_len[BW-1:0] == '0;
    assign accept = o_valid && i_out_ready;
    assign word_end = ptr[BW-1:0] == '0;
    // Only a completing word can collide with an unaccepted one.
    assign step = state == TRACE && !(word_end && o_valid && !i_out_ready);
    assign o_busy = state != IDLE;

    always_comb begin
        acc_n = acc;
        acc_n[ptr[BW-1:0]] = dec_bit(SW'(cur), K);
    end

    always_comb begin
        state_d = state;
        state_d = state == IDLE  ? (i_start && start_ok ? TRACE : IDLE)
                : state == TRACE ? (step && ptr == '0 ? FLUSH : TRACE)
                :                  (accept ? IDLE : FLUSH);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            ptr     <= '0;
            cur     <= '0;
            acc     <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            if (accept) o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr) cnt <= cnt + (AW+1)'(1);
                    if (i_dec_valid && !wr) o_ovf <= 1'b1;
                    if (i_start && !start_ok) begin
                        o_err <= 1'b1;
                        cnt   <= '0;
                    end else if (i_start) begin
                        cur   <= i_best_state;
                        ptr   <= AW'(n_len - (AW+1)'(1));
                        o_ovf <= 1'b0;
                    end
                end
                TRACE: if (step) begin
                    acc <= acc_n;
                    cur <= (K-1)'(pred_state(SW'(cur), K, rd_vec[cur]));
                    ptr <= ptr - AW'(1);
                    if (word_end) begin
                        o_data  <= acc_n;
                        o_valid <= 1'b1;
                    end
                end
                default: if (accept) begin
                    o_done <= 1'b1;
                    cnt    <= '0;
                end
            endcase
        end
    end
endmodule
